issue_queue: RTL
================

ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 SHALL have parameters: DEPTH, 16, queue entries (power of 2, >=2); ROB_W, 4, ROB tag width, tag 0 = "no dependency"; XLEN, 32, data/address width.
REQ-002 SHALL have ports: clk_in  in  1  clock, rising edge.
REQ-003 rst_n_in  in  1  reset, asynchronous, active-low.
REQ-004 rdy_in  in  1  global enable; low freezes all state.
REQ-005 in_flush  in  1  misprediction flush.
REQ-006 in_fetch_valid  in  1; in_fetch_inst  in  32; in_fetch_pc  in  XLEN; out_fetch_ready  out  1  push handshake.
REQ-007 out_count  out  log2(DEPTH)+1  occupancy.
REQ-008 in_rs_full, in_lsb_full, in_rob_full  in  1 each  downstream back-pressure.
REQ-009 out_rs1_idx, out_rs2_idx  out  5  head source registers; in_reg_rsN_busy  in  1, in_reg_rsN_data  in  XLEN, in_reg_rsN_tag  in  ROB_W (N=1,2).
REQ-010 out_rob_rsN_tag  out  ROB_W; in_rob_rsN_ready  in  1; in_rob_rsN_value  in  XLEN (N=1,2).
REQ-011 out_rs_valid, out_lsb_valid, out_rob_valid, out_reg_write, out_illegal  out  1; out_pc, out_imm, out_Vj, out_Vk  out  XLEN; out_Qj, out_Qk, out_tag  out  ROB_W; out_op  out  7; out_funct  out  10 ({funct7,funct3}); out_rd  out  5.

Function
REQ-012 Circular FIFO of DEPTH {inst,pc}; head/tail pointers wrap modulo DEPTH; count 0..DEPTH.
REQ-013 out_fetch_ready = (count<DEPTH) && !in_flush; push on rising edge when in_fetch_valid && out_fetch_ready && rdy_in; no write-through when full even if popping same cycle.
REQ-014 Head decoded combinationally: opcode class, rd/rs1/rs2, immediate (I, S, B, U, J formats, sign-extended; shift-immediates zero-extended shamt[4:0]).
REQ-015 Operand j used by all except LUI/AUIPC/JAL; operand k used only by OP, STORE, BRANCH; unused operand -> Q=0, V=0.
REQ-016 Used operand: reg not busy -> V=reg data, Q=0; busy and ROB ready -> V=ROB value, Q=0; busy and not ready -> Q=reg tag, V=0; source x0 -> Q=0, V=0 always.
REQ-017 Back-to-back bypass: if an instruction dispatched in the previous cycle with out_reg_write=1 and rd!=0 equal to a used head source, that source SHALL take Q=its out_tag, V=0, overriding REQ-016.
REQ-018 Target unit: LOAD/STORE -> LSB; all other legal opcodes -> RS; unsupported opcode -> ROB only, out_illegal=1.
REQ-019 Dispatch fires when rdy_in && !in_flush && count>0 && !in_rob_full && target not full; fires pop head in same edge.
REQ-020 Outputs registered: on firing edge, valid flags for ROB and target unit set, payload latched; valids SHALL be single-cycle pulses, cleared next edge unless another dispatch fires.
REQ-021 out_reg_write=0 for STORE, BRANCH, illegal, and rd=0; 1 otherwise.
REQ-022 Internal tag counter, reset 1, assigned to out_tag on dispatch, increments per dispatch, wraps (2^ROB_W)-1 -> 1, never 0.
REQ-023 Latency: entry pushed at edge N dispatches at edge N+1 at earliest; valids high in cycle after N+1.
REQ-024 Simultaneous push and pop: count unchanged, both pointers advance.
REQ-025 in_flush (with rdy_in high): next edge count=0, pointers=0, valids=0, tag counter=1, bypass history cleared; flush dominates push and dispatch.
REQ-026 rdy_in low: no push, no pop, valids and payload held, tag counter held.

Reset
REQ-027 rst_n_in low asynchronously: pointers 0, count 0, all valids 0, payload 0, tag counter 1, bypass history invalid; out_fetch_ready=1 after release.
REQ-028 Reset mid-operation discards all entries; no valid pulse after release until a new push.

Verification
REQ-029 Push ADDI x1,x0,5 (0x00500093) pc 0x0 into empty queue -> one cycle later out_rs_valid=out_rob_valid=1, out_imm=5, Qj=0, Vj=0, out_tag=1, out_rd=1.
REQ-030 Push ADDI x1,x0,5 then ADD x2,x1,x1 (0x00108133), regfile reports x1 not busy -> second dispatch Qj=Qk=1 via bypass, out_tag=2.
REQ-031 DEPTH=16 pushes with in_rs_full=1 -> count=16, out_fetch_ready=0; release in_rs_full -> 16 dispatches on consecutive cycles, head wraps, tag wraps 15->1.
REQ-032 SW x2,4(x1) (0x0020A223), x1 busy tag 3 ROB not ready, x2 free data 0xDEAD -> out_lsb_valid=1, out_rs_valid=0, Qj=3, Vk=0xDEAD, out_reg_write=0, imm=4.
REQ-033 Queue holding 5 entries, in_flush for one cycle with concurrent push -> count=0, no valid pulses, next dispatch out_tag=1.
REQ-034 Opcode 0x7F at head -> out_rob_valid=1, out_illegal=1, out_rs_valid=out_lsb_valid=0; rst_n_in low mid-stream -> all valids 0 immediately.

Source files
------------

// File: rtl/issue_queue.sv
// issue_queue: in-order instruction FIFO that decodes its head, resolves source operands
// and dispatches one instruction per cycle to the RS or LSB plus the ROB.
module issue_queue #(
    parameter int DEPTH = 16,
    parameter int ROB_W = 4,
    parameter int XLEN  = 32
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    rdy_in,
    input  logic                    in_flush,
    input  logic                    in_fetch_valid,
    input  logic [31:0]             in_fetch_inst,
    input  logic [XLEN-1:0]         in_fetch_pc,
    output logic                    out_fetch_ready,
    output logic [$clog2(DEPTH):0]  out_count,
    input  logic                    in_rs_full,
    input  logic                    in_lsb_full,
    input  logic                    in_rob_full,
    output logic [4:0]              out_rs1_idx,
    output logic [4:0]              out_rs2_idx,
    input  logic                    in_reg_rs1_busy,
    input  logic [XLEN-1:0]         in_reg_rs1_data,
    input  logic [ROB_W-1:0]        in_reg_rs1_tag,
    input  logic                    in_reg_rs2_busy,
    input  logic [XLEN-1:0]         in_reg_rs2_data,
    input  logic [ROB_W-1:0]        in_reg_rs2_tag,
    output logic [ROB_W-1:0]        out_rob_rs1_tag,
    output logic [ROB_W-1:0]        out_rob_rs2_tag,
    input  logic                    in_rob_rs1_ready,
    input  logic [XLEN-1:0]         in_rob_rs1_value,
    input  logic                    in_rob_rs2_ready,
    input  logic [XLEN-1:0]         in_rob_rs2_value,
    output logic                    out_rs_valid,
    output logic                    out_lsb_valid,
    output logic                    out_rob_valid,
    output logic                    out_reg_write,
    output logic                    out_illegal,
    output logic [XLEN-1:0]         out_pc,
    output logic [XLEN-1:0]         out_imm,
    output logic [XLEN-1:0]         out_Vj,
    output logic [XLEN-1:0]         out_Vk,
    output logic [ROB_W-1:0]        out_Qj,
    output logic [ROB_W-1:0]        out_Qk,
    output logic [ROB_W-1:0]        out_tag,
    output logic [6:0]              out_op,
    output logic [9:0]              out_funct,
    output logic [4:0]              out_rd
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CAP = (AW+1)'(DEPTH);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    typedef struct packed {
        logic [XLEN-1:0]  pc, imm, vj, vk;
        logic [ROB_W-1:0] qj, qk, tag;
        logic [6:0]       op;
        logic [9:0]       funct;
        logic [4:0]       rd;
        logic             reg_write, illegal;
    } disp_t;

    logic [31:0]      inst_q [DEPTH];
    logic [XLEN-1:0]  pc_q [DEPTH];
    logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [AW:0]      count_q, count_d;
    logic [ROB_W-1:0] tag_q, tag_d;
    logic             rs_v_q, rs_v_d, lsb_v_q, lsb_v_d, rob_v_q, rob_v_d;
    disp_t            disp_q, disp_d;

    logic [31:0]      inst, imm32;
    logic [6:0]       opcode;
    logic             is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store, is_opimm, is_op;
    logic             illegal, is_mem, use_j, use_k, shift, byp, reg_write, push, fire;
    logic [ROB_W-1:0] qj, qk;
    logic [XLEN-1:0]  vj, vk;

    assign inst      = inst_q[head_q];
    assign opcode    = inst[6:0];
    assign is_lui    = opcode == OP_LUI;
    assign is_auipc  = opcode == OP_AUIPC;
    assign is_jal    = opcode == OP_JAL;
    assign is_jalr   = opcode == OP_JALR;
    assign is_branch = opcode == OP_BRANCH;
    assign is_load   = opcode == OP_LOAD;
    assign is_store  = opcode == OP_STORE;
    assign is_opimm  = opcode == OP_OPIMM;
    assign is_op     = opcode == OP_OP;
    assign illegal   = !(is_lui | is_auipc | is_jal | is_jalr | is_branch | is_load | is_store | is_opimm | is_op);
    assign is_mem    = is_load | is_store;
    assign use_j     = !(is_lui | is_auipc | is_jal);
    assign use_k     = is_op | is_store | is_branch;
    // SLLI/SRLI/SRAI carry funct7 in the upper bits, so only the shamt is an immediate
    assign shift     = is_opimm && inst[13:12] == 2'b01;

    assign imm32 = (is_lui | is_auipc)            ? {inst[31:12], 12'b0}
                 : is_jal                         ? {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0}
                 : is_branch                      ? {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0}
                 : is_store                       ? {{20{inst[31]}}, inst[31:25], inst[11:7]}
                 : shift                          ? {27'b0, inst[24:20]}
                 : (is_jalr | is_load | is_opimm) ? {{20{inst[31]}}, inst[31:20]}
                 : 32'b0;

    assign out_rs1_idx     = inst[19:15];
    assign out_rs2_idx     = inst[24:20];
    assign out_rob_rs1_tag = in_reg_rs1_tag;
    assign out_rob_rs2_tag = in_reg_rs2_tag;

    // The previous dispatch has not reached the register file yet: forward its tag.
    assign byp = rob_v_q && disp_q.reg_write;

    assign {qj, vj} = (!use_j || out_rs1_idx == 5'd0)     ? {(ROB_W+XLEN){1'b0}}
                    : (byp && disp_q.rd == out_rs1_idx)   ? {disp_q.tag, {XLEN{1'b0}}}
                    : !in_reg_rs1_busy                    ? {{ROB_W{1'b0}}, in_reg_rs1_data}
                    : in_rob_rs1_ready                    ? {{ROB_W{1'b0}}, in_rob_rs1_value}
                    : {in_reg_rs1_tag, {XLEN{1'b0}}};
    assign {qk, vk} = (!use_k || out_rs2_idx == 5'd0)     ? {(ROB_W+XLEN){1'b0}}
                    : (byp && disp_q.rd == out_rs2_idx)   ? {disp_q.tag, {XLEN{1'b0}}}
                    : !in_reg_rs2_busy                    ? {{ROB_W{1'b0}}, in_reg_rs2_data}
                    : in_rob_rs2_ready                    ? {{ROB_W{1'b0}}, in_rob_rs2_value}
                    : {in_reg_rs2_tag, {XLEN{1'b0}}};

    assign reg_write       = !(is_store | is_branch | illegal) && inst[11:7] != 5'd0;
    assign out_fetch_ready = count_q < CAP && !in_flush;
    assign push            = in_fetch_valid && out_fetch_ready && rdy_in;
    assign fire            = rdy_in && !in_flush && count_q != '0 && !in_rob_full
                             && !(is_mem ? in_lsb_full : (!illegal && in_rs_full));

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        tag_d   = tag_q;
        rs_v_d  = rs_v_q;
        lsb_v_d = lsb_v_q;
        rob_v_d = rob_v_q;
        disp_d  = disp_q;
        if (rdy_in && in_flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            tag_d   = ROB_W'(1);
            rs_v_d  = 1'b0;
            lsb_v_d = 1'b0;
            rob_v_d = 1'b0;
        end else if (rdy_in) begin
            head_d  = fire ? head_q + AW'(1) : head_q;
            tail_d  = push ? tail_q + AW'(1) : tail_q;
            count_d = count_q + (AW+1)'(push) - (AW+1)'(fire);
            tag_d   = !fire ? tag_q : (&tag_q ? ROB_W'(1) : tag_q + ROB_W'(1));
            rs_v_d  = fire && !is_mem && !illegal;
            lsb_v_d = fire && is_mem;
            rob_v_d = fire;
            disp_d  = fire ? {pc_q[head_q], XLEN'($signed(imm32)), vj, vk, qj, qk, tag_q, opcode,
                              inst[31:25], inst[14:12], inst[11:7], reg_write, illegal} : disp_q;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            tag_q   <= ROB_W'(1);
            rs_v_q  <= 1'b0;
            lsb_v_q <= 1'b0;
            rob_v_q <= 1'b0;
            disp_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            tag_q   <= tag_d;
            rs_v_q  <= rs_v_d;
            lsb_v_q <= lsb_v_d;
            rob_v_q <= rob_v_d;
            disp_q  <= disp_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) begin
            inst_q[tail_q] <= in_fetch_inst;
            pc_q[tail_q]   <= in_fetch_pc;
        end
    end

    assign out_count     = count_q;
    assign out_rs_valid  = rs_v_q;
    assign out_lsb_valid = lsb_v_q;
    assign out_rob_valid = rob_v_q;
    assign out_pc        = disp_q.pc;
    assign out_imm       = disp_q.imm;
    assign out_Vj        = disp_q.vj;
    assign out_Vk        = disp_q.vk;
    assign out_Qj        = disp_q.qj;
    assign out_Qk        = disp_q.qk;
    assign out_tag       = disp_q.tag;
    assign out_op        = disp_q.op;
    assign out_funct     = disp_q.funct;
    assign out_rd        = disp_q.rd;
    assign out_reg_write = disp_q.reg_write;
    assign out_illegal   = disp_q.illegal;
endmodule
